// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg : SPECIAL funct codes and decode helpers for the muldiv unit
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  localparam logic [5:0] SPECIAL_MTHI  = 6'h11;
  localparam logic [5:0] SPECIAL_MTLO  = 6'h13;
  localparam logic [5:0] SPECIAL_MULT  = 6'h18;
  localparam logic [5:0] SPECIAL_MULTU = 6'h19;
  localparam logic [5:0] SPECIAL_DIV   = 6'h1A;
  localparam logic [5:0] SPECIAL_DIVU  = 6'h1B;

  function automatic logic is_iterative(input logic [5:0] funct);
    return (funct == SPECIAL_MULT) || (funct == SPECIAL_MULTU) ||
           (funct == SPECIAL_DIV)  || (funct == SPECIAL_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] funct);
    return (funct == SPECIAL_MULT) || (funct == SPECIAL_DIV);
  endfunction

  function automatic logic is_div_op(input logic [5:0] funct);
    return (funct == SPECIAL_DIV) || (funct == SPECIAL_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step : one combinational shift-add / restoring-divide iteration
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             is_div_i,
  output logic [2*WIDTH:0] acc_o,
  output logic [WIDTH:0]   rem_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    // Divide keeps the dividend/quotient in acc[WIDTH-1:0], MSB first.
    shifted = {rem_i, acc_i[WIDTH-1]};
    trial   = shifted - {2'b00, operand_i};
    acc_o   = {1'b0, sum, acc_i[WIDTH-1:1]};
    rem_o   = rem_i;
    if (is_div_i) begin
      if (trial[WIDTH+1]) begin
        rem_o = shifted[WIDTH:0];
        acc_o = {acc_i[2*WIDTH:WIDTH], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        rem_o = trial[WIDTH:0];
        acc_o = {acc_i[2*WIDTH:WIDTH], acc_i[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit : iterative MULT/DIV unit owning the architectural HI/LO pair
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             w_start,
  input  logic [5:0]       w_op_code_6,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  input  logic             w_flush,
  output logic             w_busy,
  output logic             w_done,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2*WIDTH:0] acc_q, acc_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;
  logic             is_div_q, neg_q, rem_neg_q, dz_q, done_q;

  logic             accept, sgn;
  logic [WIDTH-1:0] mag1, mag2;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quot_s, rem_s;

  assign accept = w_start && !w_flush;
  assign sgn    = is_signed_op(w_op_code_6);
  assign mag1   = (sgn && w_input1_x[WIDTH-1]) ? -w_input1_x : w_input1_x;
  assign mag2   = (sgn && w_input2_x[WIDTH-1]) ? -w_input2_x : w_input2_x;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .rem_i     (rem_q),
    .operand_i (opnd_q),
    .is_div_i  (is_div_q),
    .acc_o     (acc_d),
    .rem_o     (rem_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_iterative(w_op_code_6)) state_d = ST_RUN;
      ST_RUN: begin
        if (w_flush)                            state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(WIDTH - 1))    state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (state_q != ST_IDLE);
    w_done = done_q;
    w_hi_x = hi_q;
    w_lo_x = lo_q;
  end

  // Sign fix-up; a zero divisor forces LO to all ones while HI (remainder
  // re-signed with the dividend) naturally reproduces the raw dividend.
  always_comb begin
    prod_s = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quot_s = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    if (is_div_q) begin
      hi_d = rem_s;
      lo_d = dz_q ? '1 : quot_s;
    end else begin
      hi_d = prod_s[2*WIDTH-1:WIDTH];
      lo_d = prod_s[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (w_op_code_6 == SPECIAL_MTHI) begin
              hi_q <= w_input1_x;
            end else if (w_op_code_6 == SPECIAL_MTLO) begin
              lo_q <= w_input1_x;
            end else if (is_iterative(w_op_code_6)) begin
              cnt_q     <= '0;
              acc_q     <= {{(WIDTH+1){1'b0}}, mag1};
              rem_q     <= '0;
              opnd_q    <= mag2;
              is_div_q  <= is_div_op(w_op_code_6);
              neg_q     <= sgn && (w_input1_x[WIDTH-1] ^ w_input2_x[WIDTH-1]);
              rem_neg_q <= sgn && w_input1_x[WIDTH-1];
              dz_q      <= (w_input2_x == '0);
            end
          end
        end
        ST_RUN: begin
          if (!w_flush) begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_FIX: begin
          if (!w_flush) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit : self-checking bench for muldiv_unit against an arithmetic model
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        w_start = 1'b0;
  logic [5:0]  w_op_code_6 = '0;
  logic [31:0] w_input1_x = '0;
  logic [31:0] w_input2_x = '0;
  logic        w_flush = 1'b0;
  logic        w_busy, w_done;
  logic [31:0] w_hi_x, w_lo_x;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .w_start     (w_start),
    .w_op_code_6 (w_op_code_6),
    .w_input1_x  (w_input1_x),
    .w_input2_x  (w_input2_x),
    .w_flush     (w_flush),
    .w_busy      (w_busy),
    .w_done      (w_done),
    .w_hi_x      (w_hi_x),
    .w_lo_x      (w_lo_x)
  );

  always #5 clock = ~clock;

  // Architectural result of one MULT/DIV instruction.
  task automatic ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sp;
    logic [63:0] up;
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    hi = '0; lo = '0;
    case (op)
      F_MULT: begin
        sp = 64'(sa) * 64'(sb);
        hi = sp[63:32]; lo = sp[31:0];
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32]; lo = up[31:0];
      end
      F_DIV: begin
        if (b == 0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      F_DIVU: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    w_op_code_6 = op; w_input1_x = a; w_input2_x = b; w_start = 1'b1;
    @(posedge clock);
    #1 w_start = 1'b0;
  endtask

  // Issues an op and follows it until w_done (bounded); reports latency,
  // cycles with busy low, and whether HI/LO moved before done.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_lo, output bit early);
    logic [31:0] h0, l0;
    h0 = w_hi_x; l0 = w_lo_x;
    issue(op, a, b);
    lat = 0; busy_lo = 0; early = 0;
    while (!w_done && lat < 40) begin
      if (!w_busy) busy_lo++;
      if (w_hi_x !== h0 || w_lo_x !== l0) early = 1;
      lat++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++; if (w_hi_x !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want %h", w_hi_x, 32'h0); end
    vectors++; if (w_lo_x !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h want %h", w_lo_x, 32'h0); end
    vectors++; if (w_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", w_busy); end
    vectors++; if (w_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", w_done); end
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int dones;
    issue(F_MTHI, 32'h55, 32'h0);
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    vectors++; if (w_busy !== 1'b0) begin miscompares++; $display("FAIL midrun_busy: got %b want 0", w_busy); end
    vectors++; if (w_hi_x !== 32'h0) begin miscompares++; $display("FAIL midrun_hi: got %h want 0", w_hi_x); end
    vectors++; if (w_lo_x !== 32'h0) begin miscompares++; $display("FAIL midrun_lo: got %h want 0", w_lo_x); end
    @(negedge clock) reset = 1'b0;
    dones = 0;
    repeat (40) begin @(posedge clock); #1 if (w_done) dones++; end
    vectors++; if (dones != 0) begin miscompares++; $display("FAIL midrun_no_done: got %0d pulses want 0", dones); end
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic check_arith(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat, busy_lo;
    bit early;
    logic [31:0] rh, rl;
    ref_model(op, a, b, rh, rl);
    run_op(op, a, b, lat, busy_lo, early);
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL latency op=%h a=%h b=%h: got %0d want 33", op, a, b, lat); end
    vectors++; if (busy_lo != 0 || w_busy !== 1'b0) begin miscompares++; $display("FAIL busy_window op=%h: busy-low cycles %0d, busy at done %b, want 0/0", op, busy_lo, w_busy); end
    vectors++; if (early) begin miscompares++; $display("FAIL hold_until_done op=%h: got early change 1 want 0", op); end
    vectors++; if (w_hi_x !== rh) begin miscompares++; $display("FAIL hi op=%h a=%h b=%h: got %h want %h", op, a, b, w_hi_x, rh); end
    vectors++; if (w_lo_x !== rl) begin miscompares++; $display("FAIL lo op=%h a=%h b=%h: got %h want %h", op, a, b, w_lo_x, rl); end
    @(posedge clock); #1;
    vectors++; if (w_done !== 1'b0) begin miscompares++; $display("FAIL done_pulse op=%h: got %b want 0", op, w_done); end
    exp_hi = rh; exp_lo = rl;
  endtask

  task automatic test_directed;
    logic [5:0]  ops [7] = '{F_MULTU, F_MULT, F_DIV, F_DIVU, F_DIVU, F_DIV, F_DIV};
    logic [31:0] as  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] bs  [7] = '{32'hFFFF_FFFF, 32'h7, 32'h2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 7; i++) check_arith(ops[i], as[i], bs[i]);
  endtask

  task automatic test_random;
    logic [5:0] codes [6] = '{F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
    logic [5:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = codes[$urandom_range(0, 5)];
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 9) == 0) b = b & 32'hFF;
      if (op == F_MTHI || op == F_MTLO) begin
        issue(op, a, b);
        if (op == F_MTHI) exp_hi = a; else exp_lo = a;
        vectors++; if (w_hi_x !== exp_hi || w_lo_x !== exp_lo) begin miscompares++; $display("FAIL mt_move op=%h: got %h/%h want %h/%h", op, w_hi_x, w_lo_x, exp_hi, exp_lo); end
        vectors++; if (w_busy !== 1'b0 || w_done !== 1'b0) begin miscompares++; $display("FAIL mt_flags op=%h: got busy %b done %b want 0 0", op, w_busy, w_done); end
      end else begin
        check_arith(op, a, b);
      end
    end
  endtask

  task automatic test_flush;
    int dones;
    issue(F_MTHI, 32'hDEAD_BEEF, 32'h0);
    issue(F_MTLO, 32'h1234_5678, 32'h0);
    exp_hi = 32'hDEAD_BEEF; exp_lo = 32'h1234_5678;
    issue(F_MULT, 32'h0000_0123, 32'hFFFF_0005);
    repeat (4) @(posedge clock);
    @(negedge clock) w_flush = 1'b1;
    @(posedge clock); #1 w_flush = 1'b0;
    vectors++; if (w_busy !== 1'b0) begin miscompares++; $display("FAIL flush_run_busy: got %b want 0", w_busy); end
    // Flush landing exactly in the fix-up cycle.
    issue(F_DIVU, 32'd1000, 32'd3);
    repeat (32) @(posedge clock);
    @(negedge clock) w_flush = 1'b1;
    dones = 0;
    @(posedge clock); #1 w_flush = 1'b0;
    repeat (40) begin if (w_done) dones++; @(posedge clock); #1; end
    vectors++; if (dones != 0) begin miscompares++; $display("FAIL flush_no_done: got %0d pulses want 0", dones); end
    vectors++; if (w_hi_x !== exp_hi) begin miscompares++; $display("FAIL flush_hi: got %h want %h", w_hi_x, exp_hi); end
    vectors++; if (w_lo_x !== exp_lo) begin miscompares++; $display("FAIL flush_lo: got %h want %h", w_lo_x, exp_lo); end
  endtask

  task automatic test_busy_ignore;
    int n;
    issue(F_DIVU, 32'd1000, 32'd7);
    repeat (2) @(posedge clock);
    @(negedge clock);
    w_op_code_6 = F_MTLO; w_input1_x = 32'h1; w_start = 1'b1;
    @(posedge clock); #1 w_start = 1'b0;
    n = 0;
    while (!w_done && n < 40) begin n++; @(posedge clock); #1; end
    vectors++; if (!w_done) begin miscompares++; $display("FAIL busy_ignore_done: got no done within %0d cycles want done", n); end
    vectors++; if (w_lo_x !== 32'd142) begin miscompares++; $display("FAIL busy_ignore_lo: got %h want %h", w_lo_x, 32'd142); end
    vectors++; if (w_hi_x !== 32'd6) begin miscompares++; $display("FAIL busy_ignore_hi: got %h want %h", w_hi_x, 32'd6); end
    exp_hi = 32'd6; exp_lo = 32'd142;
  endtask

  task automatic test_idle_ignores;
    @(negedge clock);
    w_op_code_6 = F_MTHI; w_input1_x = 32'hAAAA_AAAA; w_start = 1'b1; w_flush = 1'b1;
    @(posedge clock); #1;
    vectors++; if (w_hi_x !== exp_hi) begin miscompares++; $display("FAIL flush_start_mthi: got %h want %h", w_hi_x, exp_hi); end
    @(negedge clock) w_op_code_6 = F_MULT;
    @(posedge clock); #1;
    vectors++; if (w_busy !== 1'b0) begin miscompares++; $display("FAIL flush_start_mult: got busy %b want 0", w_busy); end
    @(negedge clock) begin w_flush = 1'b0; w_op_code_6 = 6'h20; end
    @(posedge clock); #1 w_start = 1'b0;
    vectors++; if (w_busy !== 1'b0 || w_hi_x !== exp_hi || w_lo_x !== exp_lo) begin miscompares++; $display("FAIL bad_funct: got busy %b %h/%h want 0 %h/%h", w_busy, w_hi_x, w_lo_x, exp_hi, exp_lo); end
  endtask

  initial begin
    test_reset;
    test_reset_mid_run;
    test_directed;
    test_random;
    test_flush;
    test_busy_ignore;
    test_idle_ignores;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
